ram_sdp_clr: RTL and testbench
==============================

Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one registered read port, usable in the same cycle.
- Adds per-byte write enables, read-valid flag, out-of-range address handling and a hardware zero-clear sequencer that runs after reset or on request.
- Serves as the general data-memory / register-storage block for later CPU and datapath labs; DATA_W=32, DEPTH=32 gives the 32x32 memory geometry used so far.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; any value >= 2, need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; when 0, no write, no read, no clear request accepted.
- wena  in  1  write request, qualified by ena.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit i gates wdata[8i+7:8i].
- ren  in  1  read request, qualified by ena.
- raddr  in  ADDR_W  read address.
- clr  in  1  single-cycle request to re-zero the whole array.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  high for exactly the cycle after an accepted read.
- busy  out  1  high while the clear sequencer owns the array.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=CLEAR, clear pointer=0, busy=1, rvalid=0, rdata=0. Array contents are not touched while rst_n is low.
- FSM CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - When ptr=DEPTH-1 is written, go to READY; busy drops in the next cycle.
  - Total busy time after rst_n rises is exactly DEPTH cycles.
- FSM READY: on (ena && clr), go to CLEAR with ptr=0; busy=1 from the next cycle.
- Clear takes priority: wena, ren and clr requests made while busy=1 are ignored. No write occurs and rvalid stays 0.
- Reset asserted mid-clear restarts the sweep from address 0.
- Write, when READY && ena && wena && waddr<DEPTH:
  - mem[waddr] byte i <= wdata byte i for each wbe[i]=1.
  - Bytes with wbe[i]=0 keep their value.
  - wbe=0 is a legal no-op.
- Read, when READY && ena && ren:
  - rdata <= (raddr<DEPTH) ? mem[raddr] : 0; rvalid <= 1.
  - Latency is 1 cycle.
  - rdata holds its last value when no read is accepted; rvalid <= 0 in that case.
- Out-of-range writes (waddr>=DEPTH) are silently dropped.
- Read and write in the same cycle at different addresses are fully independent.
- Read-during-write at the same address (macro off): rdata returns the old contents (read-first).
- clr together with wena/ren in the same READY cycle: the write and read are still performed that cycle, then the clear starts.

Optional Feature:
- Macro RAM_SDP_BYPASS_EN.
- Defined: a same-address read-during-write returns write-first data. Bytes with wbe[i]=1 come from wdata; the remaining bytes come from the old mem word.
- Undefined: read-first as above, with no forwarding mux.
- All other behaviour is identical either way.

Test Plan:
- Reset clear: release rst_n, hold ena=0 → busy=1 for exactly 32 cycles. Then read all addresses 0..31 → every rdata=0x00000000, rvalid=1 one cycle after each ren.
- Byte-enable write: write 0xDEADBEEF to addr 5 with wbe=4'b1111, then 0x11223344 to addr 5 with wbe=4'b0101 → read addr 5 returns 0xDE22BE44.
- Same-address collision: mem[7]=0xAAAAAAAA; in one cycle write 0x55555555 (wbe=1111) and read addr 7 → rdata=0xAAAAAAAA with macro off, 0x55555555 with RAM_SDP_BYPASS_EN. The next read returns 0x55555555 in both builds.
- Busy gating and soft clear: pulse clr with mem[3]=0x12345678; during busy issue a write of 0xFFFFFFFF to addr 9 and a read → no rvalid. After busy falls, reading addr 3 and addr 9 both return 0.
- Out-of-range (DATA_W=16, DEPTH=20): write 0xBEEF to addr 25 → no array change; read addr 25 → rdata=0x0000, rvalid=1. Write/read addr 19 → 0xBEEF.
- Reset mid-clear: assert rst_n low at clear cycle 10 of a soft clear, release → busy=1 for exactly DEPTH further cycles, rvalid=0 throughout.

Source files
------------

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with byte enables, registered read and a zero-clear sweep
// after reset or on clr. Define RAM_SDP_BYPASS_EN for write-first same-address reads.
module ram_sdp_clr #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                wena,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                ren,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic                clr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy
);

  localparam int                NBYTES    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                waddr_ok, raddr_ok;
  logic                wr_acc, rd_acc, clr_we;
  logic [DATA_W-1:0]   rd_word;

  assign waddr_ok = {1'b0, waddr} < DEPTH_EXT;
  assign raddr_ok = {1'b0, raddr} < DEPTH_EXT;
  assign busy     = (state_q == CLEAR);
  assign wr_acc   = !busy && ena && wena && waddr_ok;
  assign rd_acc   = !busy && ena && ren;
  // The sweep is held off while reset is low so the array is left untouched.
  assign clr_we   = busy && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      READY: begin
        if (ena && clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = raddr_ok ? mem[raddr] : '0;
`ifdef RAM_SDP_BYPASS_EN
    // Forward only the bytes being written; the rest come from the stored word.
    if (wr_acc && raddr_ok && (waddr == raddr)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed bench for ram_sdp_clr: a 32x32 instance for the main checks and a
// 16-bit x 20-word instance for out-of-range addressing.
module tb_ram_sdp_clr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ena, wena, ren, clr;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdata;
  logic        rvalid, busy;

  logic        ena2, wena2, ren2, clr2;
  logic [4:0]  waddr2, raddr2;
  logic [15:0] wdata2;
  logic [1:0]  wbe2;
  logic [15:0] rdata2;
  logic        rvalid2, busy2;

  ram_sdp_clr #(.DATA_W(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .ren(ren), .raddr(raddr), .clr(clr),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  ram_sdp_clr #(.DATA_W(16), .DEPTH(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .wena(wena2), .waddr(waddr2),
    .wdata(wdata2), .wbe(wbe2), .ren(ren2), .raddr(raddr2), .clr(clr2),
    .rdata(rdata2), .rvalid(rvalid2), .busy(busy2)
  );

`ifdef RAM_SDP_BYPASS_EN
  localparam logic [31:0] COLL = 32'h55555555;
`else
  localparam logic [31:0] COLL = 32'hAAAAAAAA;
`endif

  typedef struct {
    logic        ena;
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        ren;
    logic [4:0]  raddr;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[14];
  int   tests = 0;
  int   fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ena   = v.ena;
    wena  = v.wena;
    waddr = v.waddr;
    wdata = v.wdata;
    wbe   = v.wbe;
    ren   = v.ren;
    raddr = v.raddr;
    clr   = 1'b0;
  endtask

  task automatic idle();
    ena = 1'b0; wena = 1'b0; ren = 1'b0; clr = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
  endtask

  task automatic idle2();
    ena2 = 1'b0; wena2 = 1'b0; ren2 = 1'b0; clr2 = 1'b0;
    waddr2 = '0; raddr2 = '0; wdata2 = '0; wbe2 = '0;
  endtask

  task automatic read1(input logic [4:0] a, input logic [31:0] exp, input string name);
    idle();
    ena = 1'b1; ren = 1'b1; raddr = a;
    step();
    checkOutput({name, " rvalid"}, 32'(rvalid), 32'd1);
    checkOutput({name, " rdata"}, rdata, exp);
    idle();
  endtask

  task automatic read2(input logic [4:0] a, input logic [15:0] exp, input string name);
    idle2();
    ena2 = 1'b1; ren2 = 1'b1; raddr2 = a;
    step();
    checkOutput({name, " rvalid"}, 32'(rvalid2), 32'd1);
    checkOutput({name, " rdata"}, 32'(rdata2), 32'(exp));
    idle2();
  endtask

  // Steps until busy falls; returns the number of edges taken and whether rvalid rose.
  task automatic waitClear(output int cnt, output logic saw_rvalid);
    cnt = 0;
    saw_rvalid = 1'b0;
    while (busy && cnt < 200) begin
      step();
      cnt++;
      if (rvalid) saw_rvalid = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   cnt, c1, c2;
    logic saw;

    vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 1'b0, 5'd0,  1'b0, 32'h00000000, "wr5 full"};
    vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'h11223344, 4'h5, 1'b0, 5'd0,  1'b0, 32'h00000000, "wr5 be0101"};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd5,  1'b1, 32'hDE22BE44, "rd5 merged"};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b0, 5'd0,  1'b0, 32'hDE22BE44, "idle hold"};
    vecs[4]  = '{1'b1, 1'b1, 5'd7,  32'hAAAAAAAA, 4'hF, 1'b0, 5'd0,  1'b0, 32'hDE22BE44, "wr7 AA"};
    vecs[5]  = '{1'b1, 1'b1, 5'd7,  32'h55555555, 4'hF, 1'b1, 5'd7,  1'b1, COLL,         "collide7"};
    vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd7,  1'b1, 32'h55555555, "rd7 after"};
    vecs[7]  = '{1'b1, 1'b1, 5'd3,  32'h12345678, 4'hF, 1'b1, 5'd5,  1'b1, 32'hDE22BE44, "wr3 rd5"};
    vecs[8]  = '{1'b1, 1'b1, 5'd5,  32'hFFFFFFFF, 4'h0, 1'b1, 5'd3,  1'b1, 32'h12345678, "wbe0 rd3"};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd5,  1'b1, 32'hDE22BE44, "rd5 nochg"};
    vecs[10] = '{1'b1, 1'b1, 5'd10, 32'hCAFEBABE, 4'h8, 1'b1, 5'd3,  1'b1, 32'h12345678, "wr10 be1000"};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd10, 1'b1, 32'hCA000000, "rd10"};
    vecs[12] = '{1'b0, 1'b1, 5'd3,  32'h00000000, 4'hF, 1'b1, 5'd3,  1'b0, 32'hCA000000, "ena0 gate"};
    vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 4'h0, 1'b1, 5'd3,  1'b1, 32'h12345678, "rd3 kept"};

    idle();
    idle2();
    rst_n = 1'b0;
    step();
    step();
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset busy2", 32'(busy2), 32'd1);

    // Power-on sweep: both instances clear concurrently with ena held low.
    rst_n = 1'b1;
    cnt = 0; c1 = 0; c2 = 0;
    while ((busy || busy2) && cnt < 200) begin
      step();
      cnt++;
      if (!busy && c1 == 0) c1 = cnt;
      if (!busy2 && c2 == 0) c2 = cnt;
    end
    checkOutput("init clear len", 32'(c1), 32'd32);
    checkOutput("init clear len2", 32'(c2), 32'd20);

    for (int a = 0; a < 32; a++) read1(5'(a), 32'h0, $sformatf("zero[%0d]", a));
    step();
    checkOutput("rvalid one cycle", 32'(rvalid), 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput({vecs[i].name, " rvalid"}, 32'(rvalid), 32'(vecs[i].exp_rvalid));
      checkOutput({vecs[i].name, " rdata"}, rdata, vecs[i].exp_rdata);
    end
    idle();

    // Soft clear issued together with a write and a read, which still complete.
    ena = 1'b1; clr = 1'b1; wena = 1'b1; waddr = 5'd12; wdata = 32'h0F0F0F0F; wbe = 4'hF;
    ren = 1'b1; raddr = 5'd3;
    step();
    checkOutput("clr busy", 32'(busy), 32'd1);
    checkOutput("clr rd rvalid", 32'(rvalid), 32'd1);
    checkOutput("clr rd rdata", rdata, 32'h12345678);
    waddr = 5'd9; wdata = 32'hFFFFFFFF; raddr = 5'd9;
    waitClear(cnt, saw);
    idle();
    checkOutput("soft clear len", 32'(cnt), 32'd32);
    checkOutput("busy rvalid", 32'(saw), 32'd0);
    read1(5'd3, 32'h0, "post clr a3");
    read1(5'd9, 32'h0, "post clr a9");
    read1(5'd12, 32'h0, "post clr a12");

    // Reset landing in the middle of a soft clear.
    ena = 1'b1; wena = 1'b1; waddr = 5'd1; wdata = 32'h00000ABC; wbe = 4'hF;
    step();
    idle();
    ena = 1'b1; clr = 1'b1; ren = 1'b1; raddr = 5'd1;
    step();
    checkOutput("mid rd rdata", rdata, 32'h00000ABC);
    idle();
    for (int k = 0; k < 9; k++) step();
    rst_n = 1'b0;
    #1;
    checkOutput("mid rst busy", 32'(busy), 32'd1);
    checkOutput("mid rst rdata", rdata, 32'd0);
    step();
    rst_n = 1'b1;
    ena = 1'b1; ren = 1'b1; raddr = 5'd1; wena = 1'b1; waddr = 5'd2; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    waitClear(cnt, saw);
    idle();
    checkOutput("mid rst clear len", 32'(cnt), 32'd32);
    checkOutput("mid rst rvalid", 32'(saw), 32'd0);
    read1(5'd1, 32'h0, "mid rst a1");
    read1(5'd2, 32'h0, "mid rst a2");

    // Out-of-range addressing on the 16x20 instance.
    ena2 = 1'b1; wena2 = 1'b1; waddr2 = 5'd19; wdata2 = 16'hBEEF; wbe2 = 2'b11;
    step();
    idle2();
    read2(5'd19, 16'hBEEF, "oor a19");
    ena2 = 1'b1; wena2 = 1'b1; waddr2 = 5'd25; wdata2 = 16'hBEEF; wbe2 = 2'b11;
    step();
    idle2();
    read2(5'd25, 16'h0000, "oor a25");
    read2(5'd5, 16'h0000, "oor alias5");
    read2(5'd9, 16'h0000, "oor alias9");
    read2(5'd19, 16'hBEEF, "oor a19 kept");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
